// File: rtl/pmem_responder_if.sv
// LC-3b physical-memory line bus between a cache (master) and the memory responder (slave).
// Latency: none, this is wiring only.
// Backpressure: a request is held until pmem_resp; the slave may ignore it while busy.
interface pmem_responder_if;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         pmem_err;

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp, pmem_err
    );

    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp, pmem_err
    );
endinterface

// File: rtl/pmem_responder.sv
// Line-granular main memory: one 128-bit read or write at a time, backed by an on-chip array.
// Latency: pmem_resp pulses LATENCY cycles after accept, then one dead RECOVER cycle.
// Backpressure: requests are held by the cache; they are ignored outside IDLE.
// Optional PMEM_PROTO_CHECK_EN: sticky pmem_err on request-protocol violations.
module pmem_responder #(
    parameter int INDEX_BITS = 8,
    parameter int LATENCY    = 10
) (
    input  logic clk,
    input  logic reset,
    pmem_responder_if.slave bus
);
    localparam int         DEPTH = 1 << INDEX_BITS;
    localparam logic [7:0] LOAD  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, RECOVER} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [127:0]            wdata_q, wdata_d;
    logic [127:0]            rdata_q;
    logic [INDEX_BITS-1:0]   addr_idx;
    logic [INDEX_BITS-1:0]   rd_idx;
    logic                    load_rd;
    logic                    commit;
    logic [127:0]            mem_q [DEPTH];
    logic                    unused_addr;

    // Low nibble and upper address bits do not select a line; upper bits alias.
    assign addr_idx    = bus.pmem_address[4 +: INDEX_BITS];
    assign unused_addr = ^bus.pmem_address;

    assign bus.pmem_resp  = (state_q == RESP);
    assign bus.pmem_rdata = rdata_q;

    // Next-state, capture and array-strobe decode for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        load_rd = 1'b0;
        rd_idx  = idx_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.pmem_write || bus.pmem_read) begin
                    // Write wins when both are requested.
                    op_wr_d = bus.pmem_write;
                    idx_d   = addr_idx;
                    if (bus.pmem_write) begin
                        wdata_d = bus.pmem_wdata;
                    end
                    if (LATENCY == 1) begin
                        // No BUSY phase: the read data must come straight from the live address.
                        state_d = RESP;
                        cnt_d   = 8'd0;
                        load_rd = !bus.pmem_write;
                        rd_idx  = addr_idx;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LOAD;
                    end
                end
            end
            BUSY: begin
                // cnt_q counts BUSY cycles still to run, including this one.
                if (cnt_q == 8'd1) begin
                    state_d = RESP;
                    cnt_d   = 8'd0;
                    load_rd = !op_wr_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                commit  = op_wr_q;
                state_d = RECOVER;
            end
            RECOVER: begin
                // Dead cycle so a request still held after resp is not served again.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and captured-request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Read line register, loaded on the edge entering RESP and held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (load_rd) begin
            rdata_q <= mem_q[rd_idx];
        end
    end

    // Line array write on the edge leaving RESP; a reset on that edge cancels the commit.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

`ifdef PMEM_PROTO_CHECK_EN
    logic [11:0] ahi_q;
    logic        viol;
    logic        err_q;

    // Flag requests that change or vanish while the responder is working on them.
    always_comb begin
        viol = 1'b0;
        if (state_q == IDLE && bus.pmem_read && bus.pmem_write) begin
            viol = 1'b1;
        end
        if (state_q == BUSY) begin
            if (op_wr_q ? !bus.pmem_write : !bus.pmem_read) begin
                viol = 1'b1;
            end
            if (bus.pmem_address[15:4] != ahi_q) begin
                viol = 1'b1;
            end
            if (op_wr_q && (bus.pmem_wdata != wdata_q)) begin
                viol = 1'b1;
            end
        end
    end

    // Full captured address kept only for the checker, since upper bits alias in the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            ahi_q <= '0;
        end else if (state_q == IDLE && (bus.pmem_read || bus.pmem_write)) begin
            ahi_q <= bus.pmem_address[15:4];
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (viol) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Make a violation visible in the simulation log as well.
    always_ff @(posedge clk) begin
        if (!reset && viol) begin
            $error("pmem_responder: request protocol violation in state %0d", state_q);
        end
    end
`endif

    assign bus.pmem_err = err_q;
`else
    assign bus.pmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: three latencies share one stimulus stream, each with its own timeline model.
// Latency: model predicts resp/rdata per cycle from accept time and LATENCY.
// Backpressure: requests are held by directed tasks; the random phase ignores protocol on purpose.
module tb_pmem_responder;
    logic         clk = 1'b0;
    logic         rst_r = 1'b1;
    logic         rd_r = 1'b0;
    logic         wr_r = 1'b0;
    logic [15:0]  addr_r = '0;
    logic [127:0] wdata_r = '0;
    bit           chk_en = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 3 : ((g == 1) ? 1 : 10);

        pmem_responder_if bus ();
        assign bus.pmem_read    = rd_r;
        assign bus.pmem_write   = wr_r;
        assign bus.pmem_address = addr_r;
        assign bus.pmem_wdata   = wdata_r;

        pmem_responder #(.INDEX_BITS(8), .LATENCY(LAT)) u_dut (
            .clk   (clk),
            .reset (rst_r),
            .bus   (bus)
        );

        // Timeline model: a transaction is a record of when it was accepted and what it captured.
        logic [127:0] mm [256];
        int           e = 0;
        int           acc = 0;
        int           free_e = 0;
        bit           pend = 1'b0;
        bit           p_wr = 1'b0;
        int           p_idx = 0;
        logic [11:0]  p_ahi = '0;
        logic [127:0] p_dat = '0;
        logic [127:0] rd_m = '0;
        bit           resp_m = 1'b0;
        bit           err_m = 1'b0;

        initial begin
            for (int i = 0; i < 256; i++) mm[i] = '0;
        end

        always @(posedge clk) begin
            e++;
            if (rst_r) begin
                pend   = 1'b0;
                rd_m   = '0;
                err_m  = 1'b0;
                free_e = e + 1;
            end else begin
`ifdef PMEM_PROTO_CHECK_EN
                if (pend && e > acc && e <= acc + LAT - 1) begin
                    if ((p_wr ? !wr_r : !rd_r) || addr_r[15:4] != p_ahi || (p_wr && wdata_r != p_dat))
                        err_m = 1'b1;
                end
                if (!pend && e >= free_e && rd_r && wr_r) err_m = 1'b1;
`endif
                if (pend && e == acc + LAT) begin
                    if (p_wr) mm[p_idx] = p_dat;
                    pend = 1'b0;
                end
                if (pend && !p_wr && e == acc + LAT - 1) rd_m = mm[p_idx];
                if (!pend && e >= free_e && (rd_r || wr_r)) begin
                    pend   = 1'b1;
                    acc    = e;
                    p_wr   = wr_r;
                    p_idx  = int'(addr_r[11:4]);
                    p_ahi  = addr_r[15:4];
                    p_dat  = wdata_r;
                    free_e = e + LAT + 2;
                    if (LAT == 1 && !p_wr) rd_m = mm[p_idx];
                end
            end
            resp_m = !rst_r && pend && (e == acc + LAT - 1);
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk($sformatf("d%0d_resp", g), {127'b0, bus.pmem_resp}, {127'b0, resp_m});
                chk($sformatf("d%0d_rdata", g), bus.pmem_rdata, rd_m);
                chk($sformatf("d%0d_err", g), {127'b0, bus.pmem_err}, {127'b0, err_m});
            end
        end
    end

    // One held request on the shared bus, timed against the LATENCY=3 instance.
    task automatic txn(input bit wr, input bit rd, input logic [15:0] a, input logic [127:0] d,
                       input int chg_at, input logic [15:0] a2, input bit hold_extra, output int lat);
        @(negedge clk);
        wr_r = wr; rd_r = rd; addr_r = a; wdata_r = d;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == chg_at) addr_r = a2;
            if (g_dut[0].bus.pmem_resp) begin
                lat = k;
                break;
            end
        end
        if (hold_extra) @(negedge clk);
        rd_r = 1'b0; wr_r = 1'b0;
        @(negedge clk);
    endtask

    task automatic count_resp(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (g_dut[0].bus.pmem_resp) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        logic [127:0] w1, pat, q, r;
        w1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        pat = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
        q   = 128'h11111111_22222222_33333333_44444444;
        r   = 128'h55555555_66666666_77777777_88888888;

        repeat (3) @(negedge clk);
        chk("reset_rdata", g_dut[0].bus.pmem_rdata, 128'd0);
        chk("reset_resp", {127'b0, g_dut[0].bus.pmem_resp}, 128'd0);
        rst_r = 1'b0;
        chk_en = 1'b1;

        txn(1, 0, 16'h0120, w1, 0, 16'h0, 0, lat);
        chk("lat_wr", 128'(lat), 128'd3);
        txn(0, 1, 16'h012E, '0, 0, 16'h0, 0, lat);
        chk("lat_rd", 128'(lat), 128'd3);
        chk("rd_0120", g_dut[0].bus.pmem_rdata, w1);

        txn(0, 1, 16'h0040, '0, 0, 16'h0, 1, lat);
        chk("lat_hold", 128'(lat), 128'd3);
        txn(0, 1, 16'h0040, '0, 0, 16'h0, 0, lat);
        chk("lat_after_recover", 128'(lat), 128'd3);
        count_resp(6, cnt);
        chk("no_extra_resp", 128'(cnt), 128'd0);

        txn(1, 1, 16'h0200, {16{8'hA5}}, 0, 16'h0, 0, lat);
        txn(0, 1, 16'h0200, '0, 0, 16'h0, 0, lat);
        chk("rw_write_wins", g_dut[0].bus.pmem_rdata, {16{8'hA5}});

        @(negedge clk);
        wr_r = 1'b1; addr_r = 16'h0300; wdata_r = {16{8'hFF}};
        repeat (2) @(negedge clk);
        rst_r = 1'b1; wr_r = 1'b0;
        @(negedge clk);
        chk("mid_reset_rdata", g_dut[0].bus.pmem_rdata, 128'd0);
        rst_r = 1'b0;
        count_resp(6, cnt);
        chk("mid_reset_no_resp", 128'(cnt), 128'd0);
        txn(0, 1, 16'h0300, '0, 0, 16'h0, 0, lat);
        chk("mid_reset_discard", g_dut[0].bus.pmem_rdata, 128'd0);

        txn(1, 0, 16'h1000, pat, 0, 16'h0, 0, lat);
        txn(0, 1, 16'h0000, '0, 0, 16'h0, 0, lat);
        chk("alias_0000", g_dut[0].bus.pmem_rdata, pat);

        txn(1, 0, 16'h0500, q, 0, 16'h0, 0, lat);
        txn(1, 0, 16'h0510, r, 0, 16'h0, 0, lat);
        txn(0, 1, 16'h0500, '0, 1, 16'h0510, 0, lat);
        chk("lat_addr_chg", 128'(lat), 128'd3);
        chk("addr_chg_data", g_dut[0].bus.pmem_rdata, q);

        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rst_r = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) rd_r = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) wr_r = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) addr_r = 16'($urandom) & 16'hF07F;
            if ($urandom_range(0, 3) == 0) wdata_r = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        rst_r = 1'b0; rd_r = 1'b0; wr_r = 1'b0;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
